median_rank_filter: RTL

MEDIAN_RANK_FILTER -- requirements
Module: median_rank_filter

---
 rtl/median_rank_filter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/median_rank_filter.sv
// Order-statistic filter: loads WIN samples, odd-even transposition sort, emits median/min/max/rank.
// Latency: WIN+1 cycles from last accepted sample to median_done; result held until ready_i.
// Backpressure: ready_o only in LOAD; optional rank select compiled in with MEDIAN_RANK_SEL_EN.
module median_rank_filter #(
    parameter int DATA_W = 8,
    parameter int WIN    = 25,
    parameter int IDX_W  = 6
) (
    input  logic              clk_i_median,
    input  logic              rstn_i_median,
    input  logic              en_i_median,
    input  logic [1:0]        mode_i,
`ifdef MEDIAN_RANK_SEL_EN
    input  logic [IDX_W-1:0]  rank_i,
`endif
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i_median,
    output logic              ready_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o_median,
    output logic              median_done,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, LOAD, SORT, OUT} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIN - 1);
    localparam logic [IDX_W-1:0] MID  = IDX_W'((WIN - 1) / 2);
    localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   pass_q, pass_d;
    logic [1:0]         mode_q, mode_d;
    logic               done_q, done_d;
    logic [DATA_W-1:0]  dout_q, dout_d;
    logic [DATA_W-1:0]  win_q [WIN];
    logic [DATA_W-1:0]  win_d [WIN];
    logic [IDX_W-1:0]   sel_idx;
    logic [DATA_W-1:0]  sel_dat;
`ifdef MEDIAN_RANK_SEL_EN
    logic [IDX_W-1:0]   rank_q, rank_d;
`endif

    always_comb begin
        sel_idx = MID;
        case (mode_q)
            2'd1:    sel_idx = '0;
            2'd2:    sel_idx = LAST;
`ifdef MEDIAN_RANK_SEL_EN
            2'd3:    sel_idx = (rank_q > LAST) ? LAST : rank_q;
`endif
            default: sel_idx = MID;
        endcase
        sel_dat = '0;
        for (int i = 0; i < WIN; i++) begin
            if (sel_idx == IDX_W'(i)) sel_dat = win_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        mode_d  = mode_q;
        done_d  = done_q;
        dout_d  = dout_q;
`ifdef MEDIAN_RANK_SEL_EN
        rank_d  = rank_q;
`endif
        for (int i = 0; i < WIN; i++) win_d[i] = win_q[i];

        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                pass_d = '0;
                if (en_i_median) begin
                    state_d = LOAD;
                    mode_d  = mode_i;
`ifdef MEDIAN_RANK_SEL_EN
                    rank_d  = rank_i;
`endif
                end
            end
            LOAD: begin
                if (!en_i_median) begin
                    state_d = IDLE;
                end else if (valid_i) begin
                    for (int i = 0; i < WIN; i++) begin
                        if (cnt_q == IDX_W'(i)) win_d[i] = data_i_median;
                    end
                    if (cnt_q == LAST) begin
                        state_d = SORT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            SORT: begin
                if (!en_i_median) begin
                    state_d = IDLE;
                end else begin
                    // Pairs in one pass are disjoint, so every swap reads the pre-pass window.
                    for (int i = 0; i < WIN - 1; i++) begin
                        if (((i & 1) == int'(pass_q[0])) && (win_q[i] > win_q[i+1])) begin
                            win_d[i]   = win_q[i+1];
                            win_d[i+1] = win_q[i];
                        end
                    end
                    if (pass_q == LAST) begin
                        state_d = OUT;
                        pass_d  = '0;
                    end else begin
                        pass_d = pass_q + ONE;
                    end
                end
            end
            OUT: begin
                if (!done_q) begin
                    dout_d = sel_dat;
                    done_d = 1'b1;
                end else if (ready_i) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i_median or negedge rstn_i_median) begin
        if (!rstn_i_median) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pass_q  <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            dout_q  <= '0;
`ifdef MEDIAN_RANK_SEL_EN
            rank_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
`ifdef MEDIAN_RANK_SEL_EN
            rank_q  <= rank_d;
`endif
        end
    end

    // Window contents are only meaningful after a full LOAD, so no reset is needed.
    always_ff @(posedge clk_i_median) begin
        for (int i = 0; i < WIN; i++) win_q[i] <= win_d[i];
    end

    assign ready_o       = (state_q == LOAD);
    assign busy_o        = (state_q != IDLE);
    assign median_done   = done_q;
    assign data_o_median = dout_q;

endmodule
